sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Converts the CPU core's two SRAM-like ports into a single AXI3 master. The instruction port is read-only and the data port is read/write. The bridge sits between the CPU top and the AXI interconnect, replacing the direct inst/data SRAM connections. It supports one outstanding read and one outstanding write. Data reads win arbitration over instruction reads, and a read-after-write address hazard holds the read back.

## Interface
Parameters: none.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- inst_sram_req / inst_sram_wr / inst_sram_size  in  1/1/2  inst request, write flag (must be 0), size (0=B,1=H,2=W)
- inst_sram_addr  in  32  inst byte address
- inst_sram_addr_ok / inst_sram_data_ok  out  1/1  request accepted / read data valid
- inst_sram_rdata  out  32  read data
- data_sram_req / data_sram_wr / data_sram_size  in  1/1/2  data request, 1=write, size
- data_sram_wstrb / data_sram_addr / data_sram_wdata  in  4/32/32  byte strobe, address, write data
- data_sram_addr_ok / data_sram_data_ok  out  1/1  request accepted / read data or write response
- data_sram_rdata  out  32  read data
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1;  arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1;  rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1;  awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1;  wready  in  1
- bid/bresp/bvalid  in  4/2/1;  bready  out  1

## Operation
- Constant fields: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1, awid=wid=1, arsize/awsize={1'b0,size}.
- Read FSM states:
  - R_IDLE -> R_AR on a granted read: latch addr, size, id (0=inst, 1=data).
  - R_AR: arvalid=1; on arready, go to R_R.
  - R_R: rready=1; on rvalid, go to R_IDLE.
- Write FSM states:
  - W_IDLE -> W_REQ on an accepted data write: latch addr, size, wstrb, wdata.
  - W_REQ: awvalid and wvalid start at 1. Each drops independently after its own handshake. Go to W_B when both are done; either order, or the same cycle.
  - W_B: bready=1; on bvalid, go to W_IDLE.
- Read grant (R_IDLE only): a data read (data_sram_req & ~data_sram_wr) wins over inst_sram_req.
- RAW block: no read is granted while the write FSM is not in W_IDLE and the read addr[31:2] equals the latched write addr[31:2].
- Write accept: data_sram_req & data_sram_wr while the write FSM is in W_IDLE.
- addr_ok is combinational and high in the cycle the request is latched. At most one addr_ok per port per cycle. An inst read and a data write may both be accepted in the same cycle.
- Read completion: data_ok is a 1-cycle pulse on the port selected by the latched id when rvalid&rready. rdata passes straight through from AXI rdata in the same cycle.
- Write completion: data_sram_data_ok pulses when bvalid&bready. Write completion and data-read completion are never simultaneous, because a data read cannot be granted while a data write is outstanding on the same port.
- rresp and bresp are ignored.

## Timing
- Reset values: all valid/ready outputs, addr_ok and data_ok are 0; araddr/awaddr/wdata/wstrb are 0; both FSMs are in IDLE.
- Read, zero-wait slave: request in cycle 0 (addr_ok), arvalid in cycle 1, rready in cycle 2, data_ok in cycle 2 at the earliest. Latency is 3 cycles.
- Write, zero-wait slave: addr_ok in cycle 0, awvalid/wvalid in cycle 1, bready in cycle 2, data_ok in cycle 2 at the earliest.
- arvalid/awvalid/wvalid are held with stable payload until their handshake completes.
- The next read may be granted in the cycle the FSM returns to R_IDLE, i.e. one cycle after the r handshake.
- Reset asserted mid-transaction abandons the transaction. The AXI slave is reset together with the bridge.

## Test plan
- Inst read 0x1C000000, zero-wait slave returning 0x02800000 -> addr_ok in cycle 0, arvalid in cycle 1 with arid=0 and arsize=2, inst_sram_data_ok plus rdata=0x02800000 in cycle 2.
- Data and inst reads requested in the same cycle -> data accepted first (arid=1). Inst addr_ok only after the data read's rvalid, one cycle later.
- Data write 0x1000 with wstrb=4'b0011, size=1; awready at cycle 3, wready at cycle 1 -> wvalid drops after cycle 1, awvalid is held until cycle 3, data_ok on bvalid.
- Data write to 0x2004 pending, then data read of 0x2006 -> no addr_ok until bvalid. A read of 0x3000 during the same window is also stalled, since the data port is busy. An inst read of 0x2004 is stalled; an inst read of 0x4000 proceeds.
- Slave stalls arready for 5 cycles -> araddr and arvalid stay stable and no second read is accepted.
- Reset pulse while in R_R -> all outputs return to reset values and the next request is accepted normally.

Source files
------------

// File: rtl/sram_axi_bridge_if.sv
// Purpose: bus bundles for the SRAM-to-AXI bridge: one SRAM-like CPU port and one AXI3 master port.
// Latency: none; these are wiring only.
// Backpressure: SRAM side uses req/addr_ok and data_ok; AXI side uses valid/ready per channel.
//
// sram_if: master = CPU side (drives req/wr/size/wstrb/addr/wdata), slave = bridge side.
// axi_if : master = bridge side (drives AR/AW/W, rready, bready), slave = AXI memory/interconnect.

interface sram_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

interface axi_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                    input  arready,
                    input  rid, rdata, rresp, rlast, rvalid,
                    output rready,
                    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                    input  awready,
                    output wid, wdata, wstrb, wlast, wvalid,
                    input  wready,
                    input  bid, bresp, bvalid,
                    output bready);
    modport slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                    output arready,
                    output rid, rdata, rresp, rlast, rvalid,
                    input  rready,
                    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                    output awready,
                    input  wid, wdata, wstrb, wlast, wvalid,
                    output wready,
                    output bid, bresp, bvalid,
                    input  bready);
endinterface

// File: rtl/sram_axi_bridge.sv
// Purpose: merges the CPU inst (read-only) and data (read/write) SRAM ports into one AXI3 master.
// Latency: zero-wait read is 3 cycles (addr_ok c0, arvalid c1, data_ok c2); write likewise.
// Backpressure: one read and one write in flight; further requests see addr_ok=0 until the FSM idles.
//
// Ports: clk, reset (async, active-high); inst/data: sram_if.slave; axi: axi_if.master.

module sram_axi_bridge (
    input  logic   clk,
    input  logic   reset,
    sram_if.slave  inst,
    sram_if.slave  data,
    axi_if.master  axi
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q,  rready_d;
    logic [31:0] araddr_q,  araddr_d;
    logic [1:0]  arsize_q,  arsize_d;
    logic        arid_q,    arid_d;     // 0 = inst port, 1 = data port
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        bready_q,  bready_d;
    logic [31:0] awaddr_q,  awaddr_d;
    logic [1:0]  awsize_q,  awsize_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic [31:0] wdata_q,   wdata_d;

    logic w_busy;
    logic data_rd_gnt;
    logic inst_gnt;
    logic inst_hazard;
    logic data_wr_acc;

    always_comb begin
        r_state_d = r_state_q;
        w_state_d = w_state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        arid_d    = arid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;

        w_busy      = (w_state_q != W_IDLE);
        // A data read is held off for any pending write: the data port has a single
        // data_ok, so its read and write completions must never coincide. This also
        // covers the same-word hazard for data reads.
        data_rd_gnt = ~reset & (r_state_q == R_IDLE) & data.req & ~data.wr & ~w_busy;
        inst_hazard = w_busy & (inst.addr[31:2] == awaddr_q[31:2]);
        inst_gnt    = ~reset & (r_state_q == R_IDLE) & inst.req & ~data_rd_gnt & ~inst_hazard;
        data_wr_acc = ~reset & data.req & data.wr & ~w_busy;

        case (r_state_q)
            R_IDLE: begin
                if (data_rd_gnt || inst_gnt) begin
                    r_state_d = R_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = data_rd_gnt ? data.addr : inst.addr;
                    arsize_d  = data_rd_gnt ? data.size : inst.size;
                    arid_d    = data_rd_gnt;
                end
            end
            R_AR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = R_R;
                end
            end
            R_R: begin
                if (axi.rvalid) begin
                    rready_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        case (w_state_q)
            W_IDLE: begin
                if (data_wr_acc) begin
                    w_state_d = W_REQ;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = data.addr;
                    awsize_d  = data.size;
                    wstrb_d   = data.wstrb;
                    wdata_d   = data.wdata;
                end
            end
            W_REQ: begin
                // AW and W complete independently; move on once both have handshaken.
                if (axi.awready) awvalid_d = 1'b0;
                if (axi.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d  = 1'b1;
                    w_state_d = W_B;
                end
            end
            W_B: begin
                if (axi.bvalid) begin
                    bready_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= 32'd0;
            arsize_q  <= 2'd0;
            arid_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= 32'd0;
            awsize_q  <= 2'd0;
            wstrb_q   <= 4'd0;
            wdata_q   <= 32'd0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            arid_q    <= arid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
        end
    end

    assign inst.addr_ok = inst_gnt;
    assign data.addr_ok = data_rd_gnt | data_wr_acc;
    assign inst.data_ok = axi.rvalid & rready_q & ~arid_q;
    assign data.data_ok = (axi.rvalid & rready_q & arid_q) | (axi.bvalid & bready_q);
    assign inst.rdata   = axi.rdata;
    assign data.rdata   = axi.rdata;

    assign axi.arid    = {3'b000, arid_q};
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, arsize_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = 4'd1;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, awsize_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = 4'd1;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    // Inputs the bridge deliberately ignores (inst port never writes; responses/ids unchecked).
    logic unused_inputs;
    assign unused_inputs = ^{inst.wr, inst.wstrb, inst.wdata, axi.rid, axi.rresp, axi.rlast,
                             axi.bid, axi.bresp};
endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sram_if inst_if ();
    sram_if data_if ();
    axi_if  axi ();

    sram_axi_bridge dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if),
        .data  (data_if),
        .axi   (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are changed here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd0; inst_if.wstrb = 4'd0;
        inst_if.addr = 32'd0; inst_if.wdata = 32'd0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 2'd0; data_if.wstrb = 4'd0;
        data_if.addr = 32'd0; data_if.wdata = 32'd0;
        axi.arready = 0; axi.rid = 4'd0; axi.rdata = 32'd0; axi.rresp = 2'd0; axi.rlast = 0;
        axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bid = 4'd0; axi.bresp = 2'd0;
        axi.bvalid = 0;

        // ---- reset values
        #2;
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_araddr", axi.araddr, 0);
        chk("rst_awaddr", axi.awaddr, 0);
        chk("rst_wdata", axi.wdata, 0);
        chk("rst_wstrb", axi.wstrb, 0);
        chk("rst_inst_addr_ok", inst_if.addr_ok, 0);
        chk("rst_data_data_ok", data_if.data_ok, 0);
        step(); step();
        reset = 1'b0;

        // ---- inst read 0x1C000000, zero-wait slave
        step();
        inst_if.req = 1; inst_if.addr = 32'h1C00_0000; inst_if.size = 2'd2;
        #1;
        chk("ir_addr_ok_c0", inst_if.addr_ok, 1);
        chk("ir_data_addr_ok_c0", data_if.addr_ok, 0);
        step();
        inst_if.req = 0;
        #1;
        chk("ir_arvalid_c1", axi.arvalid, 1);
        chk("ir_araddr_c1", axi.araddr, 32'h1C00_0000);
        chk("ir_arid_c1", axi.arid, 0);
        chk("ir_arsize_c1", axi.arsize, 2);
        chk("ir_arlen", axi.arlen, 0);
        chk("ir_arburst", axi.arburst, 1);
        axi.arready = 1;
        step();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h0280_0000;
        #1;
        chk("ir_rready_c2", axi.rready, 1);
        chk("ir_arvalid_c2", axi.arvalid, 0);
        chk("ir_data_ok_c2", inst_if.data_ok, 1);
        chk("ir_rdata_c2", inst_if.rdata, 32'h0280_0000);
        chk("ir_dport_data_ok_c2", data_if.data_ok, 0);
        step();
        axi.rvalid = 0;
        #1;
        chk("ir_data_ok_c3", inst_if.data_ok, 0);
        chk("ir_rready_c3", axi.rready, 0);

        // ---- data and inst reads in the same cycle: data wins
        step();
        inst_if.req = 1; inst_if.addr = 32'h1C00_0004; inst_if.size = 2'd2;
        data_if.req = 1; data_if.wr = 0; data_if.addr = 32'h0000_0800; data_if.size = 2'd2;
        #1;
        chk("arb_data_addr_ok", data_if.addr_ok, 1);
        chk("arb_inst_addr_ok", inst_if.addr_ok, 0);
        step();
        data_if.req = 0;
        #1;
        chk("arb_arid", axi.arid, 1);
        chk("arb_araddr", axi.araddr, 32'h0000_0800);
        chk("arb_inst_wait_ar", inst_if.addr_ok, 0);
        axi.arready = 1;
        step();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF;
        #1;
        chk("arb_data_data_ok", data_if.data_ok, 1);
        chk("arb_data_rdata", data_if.rdata, 32'hDEAD_BEEF);
        chk("arb_inst_data_ok", inst_if.data_ok, 0);
        chk("arb_inst_wait_r", inst_if.addr_ok, 0);
        step();
        axi.rvalid = 0;
        #1;
        chk("arb_inst_addr_ok_late", inst_if.addr_ok, 1);
        step();
        inst_if.req = 0;
        #1;
        chk("arb2_arid", axi.arid, 0);
        chk("arb2_araddr", axi.araddr, 32'h1C00_0004);
        axi.arready = 1;
        step();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h1234_5678;
        #1;
        chk("arb2_inst_data_ok", inst_if.data_ok, 1);
        step();
        axi.rvalid = 0;

        // ---- data write 0x1000, wready in c1, awready in c3
        step();
        data_if.req = 1; data_if.wr = 1; data_if.addr = 32'h0000_1000; data_if.size = 2'd1;
        data_if.wstrb = 4'b0011; data_if.wdata = 32'hA5A5_1234;
        #1;
        chk("wr_addr_ok_c0", data_if.addr_ok, 1);
        step();
        data_if.req = 0; data_if.wr = 0;
        #1;
        chk("wr_awvalid_c1", axi.awvalid, 1);
        chk("wr_wvalid_c1", axi.wvalid, 1);
        chk("wr_awaddr", axi.awaddr, 32'h0000_1000);
        chk("wr_awsize", axi.awsize, 1);
        chk("wr_wstrb", axi.wstrb, 4'b0011);
        chk("wr_wdata", axi.wdata, 32'hA5A5_1234);
        chk("wr_wlast", axi.wlast, 1);
        chk("wr_awid", axi.awid, 1);
        axi.wready = 1;
        step();
        axi.wready = 0;
        #1;
        chk("wr_wvalid_c2", axi.wvalid, 0);
        chk("wr_awvalid_c2", axi.awvalid, 1);
        chk("wr_bready_c2", axi.bready, 0);
        step();
        axi.awready = 1;
        #1;
        chk("wr_awvalid_c3", axi.awvalid, 1);
        chk("wr_awaddr_c3", axi.awaddr, 32'h0000_1000);
        step();
        axi.awready = 0; axi.bvalid = 1;
        #1;
        chk("wr_awvalid_c4", axi.awvalid, 0);
        chk("wr_bready_c4", axi.bready, 1);
        chk("wr_data_ok", data_if.data_ok, 1);
        step();
        axi.bvalid = 0;
        #1;
        chk("wr_bready_c5", axi.bready, 0);
        chk("wr_data_ok_c5", data_if.data_ok, 0);

        // ---- read-after-write hazard window (write 0x2004 pending)
        step();
        data_if.req = 1; data_if.wr = 1; data_if.addr = 32'h0000_2004; data_if.size = 2'd2;
        data_if.wstrb = 4'hF; data_if.wdata = 32'h0BAD_F00D;
        #1;
        chk("raw_wr_addr_ok", data_if.addr_ok, 1);
        step();
        data_if.wr = 0; data_if.addr = 32'h0000_2006; data_if.size = 2'd1;
        #1;
        chk("raw_rd_2006_blocked", data_if.addr_ok, 0);
        step();
        data_if.addr = 32'h0000_3000; data_if.size = 2'd2;
        #1;
        chk("raw_rd_3000_blocked", data_if.addr_ok, 0);
        step();
        data_if.req = 0;
        inst_if.req = 1; inst_if.addr = 32'h0000_2004; inst_if.size = 2'd2;
        #1;
        chk("raw_inst_2004_blocked", inst_if.addr_ok, 0);
        step();
        inst_if.addr = 32'h0000_4000;
        #1;
        chk("raw_inst_4000_ok", inst_if.addr_ok, 1);
        step();
        inst_if.req = 0;
        #1;
        chk("raw_inst_araddr", axi.araddr, 32'h0000_4000);
        chk("raw_inst_arvalid", axi.arvalid, 1);
        axi.arready = 1; axi.awready = 1; axi.wready = 1;
        step();
        axi.arready = 0; axi.awready = 0; axi.wready = 0;
        axi.rvalid = 1; axi.rdata = 32'h0000_4444;
        data_if.req = 1; data_if.wr = 0; data_if.addr = 32'h0000_2006; data_if.size = 2'd1;
        #1;
        chk("raw_inst_data_ok", inst_if.data_ok, 1);
        chk("raw_bready", axi.bready, 1);
        chk("raw_rd_blocked_rr", data_if.addr_ok, 0);
        step();
        axi.rvalid = 0; axi.bvalid = 1;
        #1;
        chk("raw_wr_data_ok", data_if.data_ok, 1);
        chk("raw_rd_blocked_b", data_if.addr_ok, 0);
        step();
        axi.bvalid = 0;
        #1;
        chk("raw_rd_released", data_if.addr_ok, 1);
        step();
        data_if.req = 0;
        #1;
        chk("raw_rd_araddr", axi.araddr, 32'h0000_2006);
        chk("raw_rd_arid", axi.arid, 1);
        chk("raw_rd_arsize", axi.arsize, 1);

        // ---- arready stalled for 5 cycles; a competing inst read must wait
        inst_if.req = 1; inst_if.addr = 32'h0000_5000; inst_if.size = 2'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk("stall_arvalid", axi.arvalid, 1);
            chk("stall_araddr", axi.araddr, 32'h0000_2006);
            chk("stall_inst_addr_ok", inst_if.addr_ok, 0);
        end
        axi.arready = 1;
        step();
        axi.arready = 0;
        #1;
        chk("stall_rready", axi.rready, 1);
        chk("stall_inst_addr_ok_rr", inst_if.addr_ok, 0);

        // ---- reset pulse while in R_R (inst request still held)
        reset = 1'b1;
        #1;
        chk("mid_rst_rready", axi.rready, 0);
        chk("mid_rst_arvalid", axi.arvalid, 0);
        chk("mid_rst_araddr", axi.araddr, 0);
        chk("mid_rst_inst_addr_ok", inst_if.addr_ok, 0);
        chk("mid_rst_data_ok", data_if.data_ok, 0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_addr_ok", inst_if.addr_ok, 1);
        step();
        inst_if.req = 0;
        #1;
        chk("post_rst_araddr", axi.araddr, 32'h0000_5000);
        chk("post_rst_arid", axi.arid, 0);
        axi.arready = 1;
        step();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'hCAFE_0001;
        #1;
        chk("post_rst_data_ok", inst_if.data_ok, 1);
        chk("post_rst_rdata", inst_if.rdata, 32'hCAFE_0001);
        step();
        axi.rvalid = 0;
        #1;
        chk("post_rst_idle", axi.rready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
